i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
- Parametrised next-generation I2C slave with a built-in byte register file.
- Configurable register-address width, register depth and reset-time device address.
- Device address is software-programmable through register 0.
- Exposes a user-side write-notify strobe and a random-access read port, so surrounding logic can observe and consume master writes.
- Sits behind the board-level SCL/SDA open-drain pads; pad tristate is built outside the block from sda_t/sda_o.

Parameters:
- I2C_SLAVE_ADDR, 7'h36, reset-time 7-bit device address.
- I2C_SLAVE_REG_MODE, 1'b1: 1 = 16-bit register address (2 bytes), 0 = 8-bit.
- REG_DEPTH, 256: number of byte registers. Must be a power of 2, range 4..256.
- DEV_ADDR_PROG, 1'b1: 1 = register 0 bits[6:0] hold the live device address; 0 = register 0 is ordinary storage and the address is fixed.

Ports:
- sys_clk  input  1  system clock, 50 MHz, at least 20x SCL rate.
- sys_rst_n  input  1  synchronous active-low reset.
- scl  input  1  I2C clock from pad.
- sda_in  input  1  I2C data from pad.
- sda_t  output  1  1 = slave drives sda_o onto SDA; 0 = released.
- sda_o  output  1  SDA drive value.
- busy  output  1  high from address-matched START to STOP.
- wr_vld  output  1  one-cycle pulse per byte written by the master.
- wr_addr  output  8  register index of the write (index bits only, zero-extended).
- wr_data  output  8  byte written.
- usr_raddr  input  8  user read index; upper bits beyond log2(REG_DEPTH) are ignored.
- usr_rdata  output  8  combinational read of regfile[usr_raddr].

Behaviour:
- Reset, synchronous, while sys_rst_n=0 at a sys_clk edge:
  - sda_t=0, sda_o=1, busy=0, wr_vld=0, wr_addr=0, wr_data=0.
  - State = IDLE; all registers = 0x00, except register 0 = {1'b0, I2C_SLAVE_ADDR} when DEV_ADDR_PROG=1.
  - A reset mid-transfer releases SDA in the same edge.
- Input conditioning: scl and sda_in each pass through a 2-flop synchroniser; edges are detected on the synchronised values.
  - START/Sr: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and take priority over bit handling.
- Bit timing: data is sampled on the SCL rising edge. The slave updates sda_t/sda_o only on the SCL falling edge.
- ACK: after the 8th falling edge, the slave drives sda_t=1, sda_o=0 and releases at the 9th falling edge.
- State machine (one-hot, 8-bit): IDLE=01, START=02, JUG_RW=04, RW_ADDR_16=08, RW_ADDR=10, WR_DAT=20, RD_DAT=40, STOP=80.
  - IDLE -> START on a START condition.
  - START -> JUG_RW at the first SCL falling edge.
  - JUG_RW: shift in 8 bits and compare [7:1] with the live address.
    - Mismatch -> IDLE, no ACK, SDA untouched until the next START.
    - Match, R/W=0 -> ACK, then RW_ADDR_16 if REG_MODE=1, else RW_ADDR.
    - Match, R/W=1 -> ACK, then RD_DAT.
  - RW_ADDR_16: receive the high address byte and ACK (discarded beyond the index width), then RW_ADDR.
  - RW_ADDR: receive the low byte, load the pointer (modulo REG_DEPTH), ACK, then WR_DAT.
  - WR_DAT, each byte:
    - ACK it and write regfile[ptr].
    - Pulse wr_vld one cycle after the 8th rising-edge sample, with wr_addr=ptr and wr_data=byte.
    - Then ptr=ptr+1 modulo REG_DEPTH (wraps REG_DEPTH-1 -> 0).
  - RD_DAT: byte regfile[ptr] is loaded at the ACK-release falling edge and shifted MSB first; the slave releases SDA during the master ACK bit.
    - Master ACK -> ptr+1 modulo REG_DEPTH, next byte.
    - Master NACK -> SDA released, wait for STOP/Sr.
  - Any state -> STOP on a STOP condition; STOP -> IDLE next cycle.
  - Sr in any state -> START; the pointer is retained, supporting combined write-address/read.
- busy: set when JUG_RW matches; cleared on STOP, address mismatch or reset.
- Address register (DEV_ADDR_PROG=1):
  - A write of byte 0x00 to register 0 is rejected: the register is unchanged, but the byte is still ACKed and wr_vld still pulses.
  - Other values update register 0; the new address takes effect from the next START.
  - The current transfer continues under the old address.
- Simultaneous user read and master write to the same index: usr_rdata returns the old value until the write edge.

Optional Feature:
- Macro I2C_SLV_GCALL_EN.
- Defined: address byte 0x00 (general call, R/W=0) is also ACKed, and the slave enters RW_ADDR.
- Undefined: 0x00 is treated as a mismatch (no ACK, return to IDLE).

Test Plan:
- Write burst: START, 0x6C, addr 00 05, data 19 20 33 25 04, STOP.
  - Every byte is ACKed.
  - Registers 5..9 = 19,20,33,25,04.
  - Five wr_vld pulses with wr_addr 5..9.
- Combined read: START, 0x6C, 00 05, Sr, 0x6D, read 5 bytes (ACK x4, NACK).
  - Slave returns 19,20,33,25,04.
  - SDA is released after the NACK; busy=0 after STOP.
- Wrap-around, REG_DEPTH=256: write at pointer 0xFF with data AA BB.
  - Register 0xFF=AA and register 0x00 is targeted next: 0xBB is rejected if it would be a zero address, otherwise it becomes the new address.
  - Also run with DEV_ADDR_PROG=0: 0x00=BB.
- Address reprogram: write 0x78 to register 0.
  - A following transfer to 0x36 gets no ACK and sda_t stays 0.
  - A transfer to 0x78 writes register 5=AA and reads back AA.
- Reset mid-read: assert sys_rst_n=0 while the slave drives a 0 bit.
  - sda_t=0 on the next sys_clk edge; state=IDLE.
  - Register 0 = 0x36.
- General call: address byte 0x00 with the macro defined -> ACK; undefined -> no ACK, state=IDLE.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte register file, write-notify strobe and user read port.
// General-call acceptance is compiled in when I2C_SLV_GCALL_EN is defined.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] I2C_SLAVE_ADDR     = 7'h36,
    parameter logic       I2C_SLAVE_REG_MODE = 1'b1,
    parameter int         REG_DEPTH          = 256,
    parameter logic       DEV_ADDR_PROG      = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_t,
    output logic       sda_o,
    output logic       busy,
    output logic       wr_vld,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] usr_raddr,
    output logic [7:0] usr_rdata
);
    localparam int AW = $clog2(REG_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [7:0] {
        IDLE       = 8'h01,
        START      = 8'h02,
        JUG_RW     = 8'h04,
        RW_ADDR_16 = 8'h08,
        RW_ADDR    = 8'h10,
        WR_DAT     = 8'h20,
        RD_DAT     = 8'h40,
        STOP       = 8'h80
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    scl_sync_q, scl_sync_d;
    logic [2:0]    sda_sync_q, sda_sync_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          gcall_q, gcall_d;
    logic          nack_q, nack_d;
    logic          busy_q, busy_d;
    logic          sda_t_q, sda_t_d;
    logic          sda_o_q, sda_o_d;
    logic          wr_vld_q, wr_vld_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    mem_q [REG_DEPTH];
    logic [7:0]    mem_d [REG_DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, rd_byte;
    logic [6:0] dev_addr;
    logic       addr_hit, gcall_hit, mem_we;

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
        scl_rise   = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall   = ~scl_sync_q[1] & scl_sync_q[2];
        start_det  = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
        stop_det   = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
        rx_byte    = {shift_q[6:0], sda_sync_q[1]};
        rd_byte    = mem_q[ptr_q];
        dev_addr   = DEV_ADDR_PROG ? mem_q[0][6:0] : I2C_SLAVE_ADDR;
        addr_hit   = (rx_byte[7:1] == dev_addr);
`ifdef I2C_SLV_GCALL_EN
        gcall_hit  = (rx_byte == 8'h00);
`else
        gcall_hit  = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        gcall_d   = gcall_q;
        nack_d    = nack_q;
        busy_d    = busy_q;
        sda_t_d   = sda_t_q;
        sda_o_d   = sda_o_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        if (stop_det) begin
            state_d = STOP;
            busy_d  = 1'b0;
            sda_t_d = 1'b0;
            sda_o_d = 1'b1;
        end else if (start_det) begin
            state_d = START;
            cnt_d   = '0;
            nack_d  = 1'b0;
            sda_t_d = 1'b0;
            sda_o_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                STOP: state_d = IDLE;
                START: if (scl_fall) state_d = JUG_RW;
                default: begin
                    // cnt_q counts SCL rises in the byte; 9 means the ACK clock is done
                    if (scl_rise && !nack_q) begin
                        cnt_d = (cnt_q < 4'd8) ? cnt_q + 4'd1 : 4'd9;
                        if (cnt_q < 4'd8) shift_d = rx_byte;
                        if (cnt_q == 4'd7) begin
                            unique case (state_q)
                                JUG_RW: begin
                                    if (addr_hit || gcall_hit) begin
                                        busy_d  = 1'b1;
                                        rw_d    = rx_byte[0];
                                        gcall_d = gcall_hit;
                                    end else begin
                                        state_d = IDLE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                RW_ADDR: ptr_d = rx_byte[AW-1:0];
                                WR_DAT: begin
                                    wr_vld_d            = 1'b1;
                                    wr_addr_d           = '0;
                                    wr_addr_d[AW-1:0]   = ptr_q;
                                    wr_data_d           = rx_byte;
                                    mem_we = !(DEV_ADDR_PROG && ptr_q == '0
                                               && rx_byte == 8'h00);
                                    ptr_d  = ptr_q + PTR_ONE;
                                end
                                default: ;
                            endcase
                        end
                        if (cnt_q == 4'd8 && state_q == RD_DAT) begin
                            if (sda_sync_q[1]) nack_d = 1'b1;
                            else ptr_d = ptr_q + PTR_ONE;
                        end
                    end
                    if (scl_fall && !nack_q) begin
                        if (cnt_q >= 4'd1 && cnt_q <= 4'd7) begin
                            if (state_q == RD_DAT) begin
                                sda_o_d = tx_q[6];
                                tx_d    = {tx_q[6:0], 1'b0};
                            end
                        end else if (cnt_q == 4'd8) begin
                            sda_t_d = (state_q != RD_DAT);
                            sda_o_d = (state_q == RD_DAT);
                        end else if (cnt_q == 4'd9) begin
                            cnt_d   = '0;
                            sda_t_d = 1'b0;
                            sda_o_d = 1'b1;
                            unique case (state_q)
                                JUG_RW: begin
                                    if (gcall_q) state_d = RW_ADDR;
                                    else if (rw_q) state_d = RD_DAT;
                                    else if (I2C_SLAVE_REG_MODE) state_d = RW_ADDR_16;
                                    else state_d = RW_ADDR;
                                end
                                RW_ADDR_16: state_d = RW_ADDR;
                                RW_ADDR:    state_d = WR_DAT;
                                default: ;
                            endcase
                            if (state_d == RD_DAT) begin
                                tx_d    = rd_byte;
                                sda_t_d = 1'b1;
                                sda_o_d = rd_byte[7];
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (mem_we) mem_d[ptr_q] = rx_byte;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            gcall_q    <= 1'b0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            sda_t_q    <= 1'b0;
            sda_o_q    <= 1'b1;
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < REG_DEPTH; i++)
                mem_q[i] <= (i == 0 && DEV_ADDR_PROG) ? {1'b0, I2C_SLAVE_ADDR} : 8'h00;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            gcall_q    <= gcall_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
            sda_t_q    <= sda_t_d;
            sda_o_q    <= sda_o_d;
            wr_vld_q   <= wr_vld_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            mem_q      <= mem_d;
        end
    end

    assign sda_t     = sda_t_q;
    assign sda_o     = sda_o_q;
    assign busy      = busy_q;
    assign wr_vld    = wr_vld_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign usr_rdata = mem_q[usr_raddr[AW-1:0]];
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: I2C master model driving a programmable-address slave and a fixed-address one.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int Q = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic scl_m, sda_m;
    wire  sda_bus;
    logic sda_t1, sda_o1, busy1, wr_vld1;
    logic [7:0] wr_addr1, wr_data1, raddr1, rdata1;
    logic sda_t2, sda_o2, busy2, wr_vld2;
    logic [7:0] wr_addr2, wr_data2, raddr2, rdata2;

    int checks = 0;
    int errors = 0;
    int t_cnt  = 0;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_ev_t;
    typedef struct { logic [7:0] raddr; logic [7:0] exp; } rd_vec_t;
    wr_ev_t  wq[$];
    rd_vec_t burst_tbl[5];
    rd_vec_t wrap_tbl[2];

    always #10 clk = ~clk;

    assign sda_bus = sda_m & (sda_t1 ? sda_o1 : 1'b1) & (sda_t2 ? sda_o2 : 1'b1);

    i2c_slave_regfile u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .scl(scl_m), .sda_in(sda_bus),
        .sda_t(sda_t1), .sda_o(sda_o1), .busy(busy1), .wr_vld(wr_vld1),
        .wr_addr(wr_addr1), .wr_data(wr_data1),
        .usr_raddr(raddr1), .usr_rdata(rdata1)
    );

    i2c_slave_regfile #(.I2C_SLAVE_ADDR(7'h37), .DEV_ADDR_PROG(1'b0)) u_dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .scl(scl_m), .sda_in(sda_bus),
        .sda_t(sda_t2), .sda_o(sda_o2), .busy(busy2), .wr_vld(wr_vld2),
        .wr_addr(wr_addr2), .wr_data(wr_data2),
        .usr_raddr(raddr2), .usr_rdata(rdata2)
    );

    always @(posedge clk) begin
        if (wr_vld1) wq.push_back({wr_addr1, wr_data1});
        if (sda_t1) t_cnt++;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #Q;
            scl_m = 1'b1; #(2*Q);
            scl_m = 1'b0; #Q;
        end
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = ~sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic wrb(input logic [7:0] b, input string name);
        logic ack;
        write_byte(b, ack);
        chk(name, 8'(ack), 8'd1);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl_m = 1'b1;
            #Q; b[i] = sda_bus;
            #Q; scl_m = 1'b0;
            #Q;
        end
        sda_m = ~mack; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
        sda_m = 1'b1;
    endtask

    task automatic rdb(input logic mack, input logic [7:0] exp, input string name);
        logic [7:0] b;
        read_byte(mack, b);
        chk(name, b, exp);
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_events(input string name, input rd_vec_t v);
        wr_ev_t ev;
        ev = (wq.size() != 0) ? wq.pop_front() : 16'h0;
        chk({name, "_addr"}, ev.a, v.raddr);
        chk({name, "_data"}, ev.d, v.exp);
    endtask

    initial begin
        logic       ack;
        logic [7:0] bdata[5];
        int         snap;
        bit         seen;

        burst_tbl[0] = '{8'h05, 8'h19};
        burst_tbl[1] = '{8'h06, 8'h20};
        burst_tbl[2] = '{8'h07, 8'h33};
        burst_tbl[3] = '{8'h08, 8'h25};
        burst_tbl[4] = '{8'h09, 8'h04};
        wrap_tbl[0]  = '{8'hFF, 8'hAA};
        wrap_tbl[1]  = '{8'h00, 8'h00};

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; raddr1 = 8'h00; raddr2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_t", 8'(sda_t1), 8'd0);
        chk("rst_sda_o", 8'(sda_o1), 8'd1);
        chk("rst_busy", 8'(busy1), 8'd0);
        chk("rst_wr_vld", 8'(wr_vld1), 8'd0);
        chk("rst_wr_addr", wr_addr1, 8'h00);
        chk("rst_state", 8'(u_dut.state_q), 8'h01);
        chk("rst_reg0", rdata1, 8'h36);
        chk("rst_reg0_fixed", rdata2, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        settle();

        // write burst
        wq.delete();
        i2c_start();
        wrb(8'h6C, "burst_dev_ack");
        chk("burst_busy", 8'(busy1), 8'd1);
        wrb(8'h00, "burst_ahi_ack");
        wrb(8'h05, "burst_alo_ack");
        for (int i = 0; i < 5; i++) wrb(burst_tbl[i].exp, "burst_dat_ack");
        i2c_stop();
        settle();
        chk("burst_busy_end", 8'(busy1), 8'd0);
        chk("burst_wr_cnt", 8'(wq.size()), 8'd5);
        for (int i = 0; i < 5; i++) begin
            raddr1 = burst_tbl[i].raddr; #1;
            chk("burst_reg", rdata1, burst_tbl[i].exp);
            check_events("burst_ev", burst_tbl[i]);
        end

        // combined write-address / read
        i2c_start();
        wrb(8'h6C, "cr_dev_ack");
        wrb(8'h00, "cr_ahi_ack");
        wrb(8'h05, "cr_alo_ack");
        i2c_start();
        wrb(8'h6D, "cr_rd_ack");
        for (int i = 0; i < 5; i++) read_byte(i != 4, bdata[i]);
        for (int i = 0; i < 5; i++) chk("cr_rdata", bdata[i], burst_tbl[i].exp);
        #1;
        chk("cr_nack_release", 8'(sda_t1), 8'd0);
        chk("cr_busy_pre_stop", 8'(busy1), 8'd1);
        i2c_stop();
        settle();
        chk("cr_busy_end", 8'(busy1), 8'd0);

        // reprogram device address to 0x78
        i2c_start();
        wrb(8'h6C, "rp_dev_ack");
        wrb(8'h00, "rp_ahi_ack");
        wrb(8'h00, "rp_alo_ack");
        wrb(8'h78, "rp_dat_ack");
        i2c_stop();
        settle();
        raddr1 = 8'h00; #1;
        chk("rp_reg0", rdata1, 8'h78);
        snap = t_cnt;
        i2c_start();
        write_byte(8'h6C, ack);
        chk("rp_old_nack", 8'(ack), 8'd0);
        chk("rp_old_idle", 8'(u_dut.state_q), 8'h01);
        i2c_stop();
        settle();
        chk("rp_old_sda_t", 8'(t_cnt != snap), 8'd0);
        i2c_start();
        wrb(8'hF0, "rp_new_ack");
        wrb(8'h00, "rp_new_ahi");
        wrb(8'h05, "rp_new_alo");
        wrb(8'hAA, "rp_new_dat");
        i2c_stop();
        settle();
        i2c_start();
        wrb(8'hF0, "rp_rb_dev");
        wrb(8'h00, "rp_rb_ahi");
        wrb(8'h05, "rp_rb_alo");
        i2c_start();
        wrb(8'hF1, "rp_rb_rd");
        rdb(1'b0, 8'hAA, "rp_rb_data");
        i2c_stop();
        settle();

        // wrap to register 0 with a zero byte: rejected but notified
        wq.delete();
        i2c_start();
        wrb(8'hF0, "wz_dev");
        wrb(8'h00, "wz_ahi");
        wrb(8'hFF, "wz_alo");
        wrb(8'hAA, "wz_d0");
        wrb(8'h00, "wz_d1");
        i2c_stop();
        settle();
        raddr1 = 8'hFF; #1;
        chk("wz_regff", rdata1, 8'hAA);
        raddr1 = 8'h00; #1;
        chk("wz_reg0_kept", rdata1, 8'h78);
        chk("wz_wr_cnt", 8'(wq.size()), 8'd2);
        for (int i = 0; i < 2; i++) check_events("wz_ev", wrap_tbl[i]);

        // wrap with 0xBB: new address 0x3B
        i2c_start();
        wrb(8'hF0, "wb_dev");
        wrb(8'h00, "wb_ahi");
        wrb(8'hFF, "wb_alo");
        wrb(8'hAA, "wb_d0");
        wrb(8'hBB, "wb_d1");
        i2c_stop();
        settle();
        raddr1 = 8'h00; #1;
        chk("wb_reg0", rdata1, 8'hBB);
        i2c_start();
        wrb(8'h76, "wb_new_addr_ack");
        i2c_stop();
        settle();

        // fixed-address instance: register 0 is plain storage
        i2c_start();
        wrb(8'h6E, "fx_dev");
        wrb(8'h00, "fx_ahi");
        wrb(8'hFF, "fx_alo");
        wrb(8'hAA, "fx_d0");
        wrb(8'hBB, "fx_d1");
        i2c_stop();
        settle();
        raddr2 = 8'hFF; #1;
        chk("fx_regff", rdata2, 8'hAA);
        raddr2 = 8'h00; #1;
        chk("fx_reg0", rdata2, 8'hBB);
        i2c_start();
        wrb(8'h6E, "fx_addr_kept");
        i2c_stop();
        settle();

        // general call
        i2c_start();
        write_byte(8'h00, ack);
`ifdef I2C_SLV_GCALL_EN
        chk("gc_ack", 8'(ack), 8'd1);
        chk("gc_state", 8'(u_dut.state_q), 8'h10);
`else
        chk("gc_ack", 8'(ack), 8'd0);
        chk("gc_state", 8'(u_dut.state_q), 8'h01);
`endif
        i2c_stop();
        settle();

        // reset while the slave drives a 0 during a read of 0xAA
        i2c_start();
        wrb(8'h76, "rr_dev");
        wrb(8'h00, "rr_ahi");
        wrb(8'h05, "rr_alo");
        i2c_start();
        wrb(8'h77, "rr_rd");
        #Q; scl_m = 1'b1;
        #(2*Q); scl_m = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = sda_t1 && !sda_o1;
        end
        chk("rr_drive_zero", 8'(seen), 8'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rr_sda_t", 8'(sda_t1), 8'd0);
        chk("rr_state", 8'(u_dut.state_q), 8'h01);
        raddr1 = 8'h00; #1;
        chk("rr_reg0", rdata1, 8'h36);
        raddr1 = 8'h05; #1;
        chk("rr_reg5", rdata1, 8'h00);
        scl_m = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        settle();
        chk("rr_busy", 8'(busy1), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
